trap_controller: RTL

// CSR-bus initiator for trap entry and return. On an exception or enabled interrupt at an

---
 rtl/trap_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// Trap entry / MRET sequencer driving the CSR bus; all outputs registered.
// Optional fast interrupts are enabled by defining TRAP_FAST_IRQ_EN.
module trap_controller #(
  parameter bit VECTORED_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_boundary,
  input  logic [31:0] pc_value,
  input  logic        exception_request,
  input  logic [3:0]  exception_cause,
  input  logic [31:0] exception_tval,
  input  logic        mret_request,
  input  logic        interrupt_enable,
  input  logic        interruption_request_external,
  input  logic        interruption_request_timer,
  input  logic        interruption_request_software,
  input  logic [15:0] interruption_request_fast,
  input  logic [31:0] csr_data_in,
  output logic        csr_write_enable,
  output logic [2:0]  csr_func3,
  output logic [11:0] csr_address,
  output logic [31:0] csr_data_out,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  output logic        in_handler
);

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, READ_TVEC, READ_EPC, REDIRECT
  } state_t;

  state_t      r_state, w_next;
  logic        r_irq, w_irq;
  logic [4:0]  r_code, w_code;
  logic [31:0] r_tval, w_tval;
  logic        r_we, w_we;
  logic [2:0]  r_f3, w_f3;
  logic [11:0] r_addr, w_addr;
  logic [31:0] r_dout, w_dout;
  logic        r_busy, w_busy;
  logic        r_rv, w_rv;
  logic [31:0] r_tgt, w_tgt;
  logic        r_in_handler, w_in_handler;

  logic        w_irq_en;
  logic        w_irq_take;
  logic [4:0]  w_irq_code;
  logic [15:0] w_fast_req;
  logic [31:0] w_base;
  logic [31:0] w_trap_tgt;
  logic [31:0] w_mcause;

`ifdef TRAP_FAST_IRQ_EN
  assign w_fast_req = interruption_request_fast;
`else
  assign w_fast_req = interruption_request_fast & 16'h0000;
`endif

  assign w_irq_en = interrupt_enable && !r_in_handler;

  // Fixed priority: external > software > timer > fast[0] > ... > fast[15]
  always_comb begin
    w_irq_take = 1'b0;
    w_irq_code = '0;
    if (w_irq_en) begin
      if (interruption_request_external) begin
        w_irq_take = 1'b1;
        w_irq_code = 5'd11;
      end else if (interruption_request_software) begin
        w_irq_take = 1'b1;
        w_irq_code = 5'd3;
      end else if (interruption_request_timer) begin
        w_irq_take = 1'b1;
        w_irq_code = 5'd7;
      end else begin
        for (int unsigned i = 0; i < 16; i++) begin
          if (!w_irq_take && w_fast_req[i]) begin
            w_irq_take = 1'b1;
            w_irq_code = 5'(16 + i);
          end
        end
      end
    end
  end

  assign w_base     = {csr_data_in[31:2], 2'b00};
  assign w_trap_tgt = (VECTORED_MODE && r_irq && csr_data_in[1:0] == 2'b01)
                      ? w_base + {25'b0, r_code, 2'b00} : w_base;
  assign w_mcause   = r_irq ? {1'b1, 26'b0, r_code} : {27'b0, r_code};

  // Outputs are computed for the state being entered and registered with it
  always_comb begin
    w_next       = r_state;
    w_irq        = r_irq;
    w_code       = r_code;
    w_tval       = r_tval;
    w_we         = 1'b0;
    w_f3         = 3'b000;
    w_addr       = '0;
    w_dout       = '0;
    w_rv         = 1'b0;
    w_tgt        = '0;
    w_in_handler = r_in_handler;
    unique case (r_state)
      IDLE: begin
        if (instruction_boundary) begin
          if (exception_request || w_irq_take) begin
            w_next = SAVE_EPC;
            w_irq  = !exception_request;
            w_code = exception_request ? {1'b0, exception_cause} : w_irq_code;
            w_tval = exception_request ? exception_tval : '0;
            w_we   = 1'b1;
            w_f3   = 3'b001;
            w_addr = CSR_MEPC;
            w_dout = {pc_value[31:2], 2'b00};
          end else if (mret_request) begin
            w_next = READ_EPC;
            w_addr = CSR_MEPC;
          end
        end
      end
      SAVE_EPC: begin
        w_next = SAVE_CAUSE;
        w_we   = 1'b1;
        w_f3   = 3'b001;
        w_addr = CSR_MCAUSE;
        w_dout = w_mcause;
      end
      SAVE_CAUSE: begin
        w_next = SAVE_TVAL;
        w_we   = 1'b1;
        w_f3   = 3'b001;
        w_addr = CSR_MTVAL;
        w_dout = r_tval;
      end
      SAVE_TVAL: begin
        w_next = READ_TVEC;
        w_addr = CSR_MTVEC;
      end
      READ_TVEC: begin
        w_next       = REDIRECT;
        w_rv         = 1'b1;
        w_tgt        = w_trap_tgt;
        w_in_handler = 1'b1;
      end
      READ_EPC: begin
        w_next       = REDIRECT;
        w_rv         = 1'b1;
        w_tgt        = {csr_data_in[31:2], 2'b00};
        w_in_handler = 1'b0;
      end
      REDIRECT: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    w_busy = (w_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_irq        <= 1'b0;
      r_code       <= '0;
      r_tval       <= '0;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
      r_rv         <= 1'b0;
      r_tgt        <= '0;
      r_in_handler <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_irq        <= w_irq;
      r_code       <= w_code;
      r_tval       <= w_tval;
      r_we         <= w_we;
      r_f3         <= w_f3;
      r_addr       <= w_addr;
      r_dout       <= w_dout;
      r_busy       <= w_busy;
      r_rv         <= w_rv;
      r_tgt        <= w_tgt;
      r_in_handler <= w_in_handler;
    end
  end

  assign csr_write_enable = r_we;
  assign csr_func3        = r_f3;
  assign csr_address      = r_addr;
  assign csr_data_out     = r_dout;
  assign busy             = r_busy;
  assign redirect_valid   = r_rv;
  assign redirect_target  = r_tgt;
  assign in_handler       = r_in_handler;

endmodule
